// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine driving an external synchronous table RAM (s[] of depth 2^ADDR_W).
// Define KSA_INIT_EN to include the INIT pass that writes s[i]=i before the schedule runs.
module rc4_ksa_engine #(
  parameter int ADDR_W    = 8,
  parameter int KEY_BYTES = 3
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  input  logic [ADDR_W-1:0]      q,
  output logic [ADDR_W-1:0]      address,
  output logic [ADDR_W-1:0]      data,
  output logic                   wren,
  output logic                   busy,
  output logic                   finish
);

  localparam int              KW     = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KW-1:0]   K_LAST = KW'(KEY_BYTES - 1);
  localparam logic [ADDR_W-1:0] I_LAST = '1;

  typedef enum logic [3:0] {
    IDLE,
`ifdef KSA_INIT_EN
    INIT,
`endif
    RD_SI,
    LT_SI,
    CALC_J,
    RD_SJ,
    LT_SJ,
    WR_I,
    WR_J,
    NEXT,
    DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      i_q, i_d;
  logic [ADDR_W-1:0]      j_q, j_d;
  logic [ADDR_W-1:0]      si_q, si_d;
  logic [ADDR_W-1:0]      sj_q, sj_d;
  logic [KW-1:0]          keyIdx_q, keyIdx_d;
  logic [8*KEY_BYTES-1:0] key_q, key_d;

  // Byte 0 of the key is the most significant byte of the captured key word.
  logic [7:0]        keyBytes [KEY_BYTES];
  logic [7:0]        keyByte;
  logic [ADDR_W-1:0] keyAdd;

  for (genvar b = 0; b < KEY_BYTES; b++) begin : g_keyBytes
    assign keyBytes[b] = key_q[8*(KEY_BYTES-b)-1 -: 8];
  end

  assign keyByte = keyBytes[keyIdx_q];

  if (ADDR_W <= 8) begin : g_keyNarrow
    assign keyAdd = keyByte[ADDR_W-1:0];
  end else begin : g_keyWide
    assign keyAdd = {{(ADDR_W-8){1'b0}}, keyByte};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef KSA_INIT_EN
          state_d = INIT;
`else
          state_d = RD_SI;
`endif
        end
      end
`ifdef KSA_INIT_EN
      INIT:    if (i_q == I_LAST) state_d = RD_SI;
`endif
      RD_SI:   state_d = LT_SI;
      LT_SI:   state_d = CALC_J;
      CALC_J:  state_d = RD_SJ;
      RD_SJ:   state_d = LT_SJ;
      LT_SJ:   state_d = WR_I;
      WR_I:    state_d = WR_J;
      WR_J:    state_d = NEXT;
      NEXT:    state_d = (i_q == I_LAST) ? DONE : RD_SI;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      i_q      <= '0;
      j_q      <= '0;
      si_q     <= '0;
      sj_q     <= '0;
      keyIdx_q <= '0;
      key_q    <= '0;
    end else begin
      i_q      <= i_d;
      j_q      <= j_d;
      si_q     <= si_d;
      sj_q     <= sj_d;
      keyIdx_q <= keyIdx_d;
      key_q    <= key_d;
    end
  end

  // i wraps naturally at N-1, so it is already 0 when INIT hands over and when the run ends.
  always_comb begin
    i_d      = i_q;
    j_d      = j_q;
    si_d     = si_q;
    sj_d     = sj_q;
    keyIdx_d = keyIdx_q;
    key_d    = key_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d    = secret_key;
          i_d      = '0;
          j_d      = '0;
          keyIdx_d = '0;
        end
      end
`ifdef KSA_INIT_EN
      INIT:    i_d = i_q + ADDR_W'(1);
`endif
      LT_SI:   si_d = q;
      CALC_J:  j_d = j_q + si_q + keyAdd;
      LT_SJ:   sj_d = q;
      NEXT: begin
        i_d      = i_q + ADDR_W'(1);
        keyIdx_d = (keyIdx_q == K_LAST) ? '0 : keyIdx_q + KW'(1);
      end
      default: ;
    endcase
  end

  // Read states hold the address for two cycles so q is valid in the latch state.
  always_comb begin
    address = '0;
    data    = '0;
    wren    = 1'b0;
    busy    = (state_q != IDLE);
    finish  = (state_q == DONE);
    case (state_q)
`ifdef KSA_INIT_EN
      INIT: begin
        address = i_q;
        data    = i_q;
        wren    = 1'b1;
      end
`endif
      RD_SI, LT_SI: address = i_q;
      RD_SJ, LT_SJ: address = j_q;
      WR_I: begin
        address = i_q;
        data    = sj_q;
        wren    = 1'b1;
      end
      WR_J: begin
        address = j_q;
        data    = si_q;
        wren    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/rc4_ksa_engine.md
RC4_KSA_ENGINE -- requirements
Module: rc4_ksa_engine

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, giving the state-table address/data width; table depth N = 2^ADDR_W.
REQ-002 SHALL have parameter KEY_BYTES, default 3, giving the number of key bytes; legal range 1..16.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request to run the key schedule.
REQ-006 SHALL have port secret_key, input, 8*KEY_BYTES bits: key; byte k = secret_key[8*(KEY_BYTES-k)-1 -: 8], so byte 0 is the MSB byte.
REQ-007 SHALL have port q, input, ADDR_W bits: read data from the table RAM.
REQ-008 SHALL have port address, output, ADDR_W bits: table RAM address.
REQ-009 SHALL have port data, output, ADDR_W bits: table RAM write data.
REQ-010 SHALL have port wren, output, 1 bit: table RAM write enable.
REQ-011 SHALL have port busy, output, 1 bit: high while a run is in progress.
REQ-012 SHALL have port finish, output, 1 bit: one-cycle pulse at end of run.

Function
REQ-013 SHALL assume a synchronous RAM: q reflects the address presented in the previous cycle.
REQ-014 SHALL sample start only in IDLE; start while busy is ignored.
REQ-015 SHALL capture secret_key into an internal register on the start-accept edge; later key changes do not affect the run.
REQ-016 SHALL use states IDLE, INIT, RD_SI, LT_SI, CALC_J, RD_SJ, LT_SJ, WR_I, WR_J, NEXT, DONE.
REQ-017 Transitions: IDLE->INIT (or RD_SI if init compiled out) on start; RD_SI->LT_SI->CALC_J->RD_SJ->LT_SJ->WR_I->WR_J->NEXT; NEXT->RD_SI if i!=N-1, else DONE; DONE->IDLE.
REQ-018 SHALL set i=0, j=0 and key index k=0 on run start.
REQ-019 RD_SI: address=i; LT_SI: address=i, si<=q.
REQ-020 CALC_J: j <= (j + si + keybyte[k]) mod N, using the low ADDR_W bits of the key byte.
REQ-021 RD_SJ: address=j; LT_SJ: address=j, sj<=q.
REQ-022 WR_I: address=i, data=sj, wren=1; WR_J: address=j, data=si, wren=1.
REQ-023 NEXT: i<=i+1 (mod N); k<=k+1, wrapping to 0 after KEY_BYTES-1; k SHALL be a counter, not a divider.
REQ-024 SHALL iterate all N indices 0..N-1 inclusive, exactly 8 cycles per index.
REQ-025 When i==j, both writes SHALL occur and the table value SHALL be unchanged.
REQ-026 busy SHALL be high in every non-IDLE state; finish SHALL be high only in DONE.
REQ-027 Latency: finish SHALL assert 8*N cycles after busy first rises (N+8*N with init compiled in).
REQ-028 wren SHALL be 0 outside INIT, WR_I and WR_J; address and data SHALL be 0 in IDLE and DONE.

Reset
REQ-029 On reset_n low, state SHALL become IDLE immediately; i, j, k, si, sj and the key register SHALL clear to 0.
REQ-030 Outputs during reset SHALL be wren=0, busy=0, finish=0, address=0, data=0.
REQ-031 Reset mid-run SHALL abort without completing any pending write; after release, the block SHALL wait for a new start.

Configuration
REQ-032 With KSA_INIT_EN defined, INIT SHALL write s[i]=i for i=0..N-1, one write per cycle (address=i, data=i, wren=1), then reset i to 0 and enter RD_SI.
REQ-033 Without KSA_INIT_EN, the INIT state SHALL not exist, the table SHALL be used as found, and start SHALL go directly to RD_SI.

Verification
REQ-034 ADDR_W=2, KEY_BYTES=1, KSA_INIT_EN, key=0x00 -> RAM ends [0,2,3,1]; finish 36 cycles after busy rises.
REQ-035 ADDR_W=8, KEY_BYTES=3, key=0x000249, KSA_INIT_EN -> RAM matches the software KSA model byte for byte; finish 2304 cycles after busy rises; index 255 is processed.
REQ-036 start held high continuously for 3 runs -> busy and finish timing is identical each run, there is exactly one IDLE cycle between runs, and mid-run start is ignored.
REQ-037 reset_n pulsed low at cycle 100 of a run -> outputs are 0 at once, no write occurs in the next cycle, and a fresh start completes correctly.
REQ-038 ADDR_W=8, KEY_BYTES=5, init compiled out, RAM preloaded with s[i]=255-i -> result matches the model; the key index wraps 4->0.
